// File: rtl/knapsack_stream_checker.sv
// Streaming knapsack feasibility checker: accumulates the selected items of a candidate,
// tests the totals against value floor / resource ceilings and tracks the best feasible result.
module knapsack_stream_checker #(
  parameter int VAL_W     = 8,
  parameter int ACC_W     = 12,
  parameter int N_RES     = 3,
  parameter int MAX_ITEMS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACC_W-1:0]       min_value,
  input  logic [N_RES*ACC_W-1:0] max_res,
  input  logic                   item_valid,
  output logic                   item_ready,
  input  logic                   item_sel,
  input  logic [VAL_W-1:0]       item_value,
  input  logic [N_RES*VAL_W-1:0] item_res,
  input  logic                   item_last,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_ok,
  output logic [ACC_W-1:0]       res_value,
  output logic [N_RES-1:0]       res_fail_mask,
  output logic                   res_len_err,
  output logic [15:0]            res_id,
  output logic                   best_valid,
  output logic [ACC_W-1:0]       best_value,
  output logic [15:0]            best_id
);

  localparam int CNT_W = $clog2(MAX_ITEMS + 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                       state, state_nxt;
  logic [ACC_W-1:0]             value_acc, value_nxt, thr_min;
  logic [N_RES-1:0][ACC_W-1:0]  res_acc, res_nxt, thr_res;
  logic [N_RES-1:0]             sat, sat_new, fail;
  logic [CNT_W-1:0]             count, count_inc;
  logic                         len_err, hit_max;
  logic [15:0]                  id;
  logic                         accept, handshake, feasible, better;
  logic [ACC_W:0]               value_sum;
  logic [ACC_W:0]               res_sum;

  assign accept    = item_valid & item_ready;
  assign handshake = res_valid & res_ready;
  assign count_inc = count + 1'b1;
  assign hit_max   = (count_inc == CNT_W'(MAX_ITEMS));

  // Saturating adders: the carry out of an ACC_W+1 bit sum flags overflow.
  always_comb begin
    value_sum = {1'b0, value_acc} + {{(ACC_W + 1 - VAL_W){1'b0}}, item_value};
    value_nxt = value_sum[ACC_W] ? '1 : value_sum[ACC_W-1:0];
    res_nxt   = res_acc;
    sat_new   = '0;
    res_sum   = '0;
    for (int unsigned r = 0; r < N_RES; r++) begin
      res_sum    = {1'b0, res_acc[r]} + {{(ACC_W + 1 - VAL_W){1'b0}}, item_res[r*VAL_W +: VAL_W]};
      sat_new[r] = res_sum[ACC_W];
      res_nxt[r] = res_sum[ACC_W] ? '1 : res_sum[ACC_W-1:0];
    end
  end

  always_comb begin
    fail = '0;
    for (int unsigned r = 0; r < N_RES; r++) begin
      fail[r] = sat[r] | (res_acc[r] > thr_res[r]);
    end
  end

  always_comb begin
    state_nxt  = state;
    item_ready = 1'b0;
    res_valid  = 1'b0;
    unique case (state)
      ACCUM: begin
        item_ready = 1'b1;
        if (accept && (item_last || hit_max)) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  assign feasible      = (value_acc >= thr_min) & ~|fail & ~len_err;
  assign res_ok        = res_valid & feasible;
  assign res_fail_mask = res_valid ? fail : '0;
  assign res_value     = res_valid ? value_acc : '0;
  assign res_len_err   = res_valid & len_err;
  assign res_id        = id;
  assign better        = res_ok & (~best_valid | (value_acc > best_value));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      value_acc  <= '0;
      res_acc    <= '0;
      sat        <= '0;
      thr_min    <= '0;
      thr_res    <= '0;
      count      <= '0;
      len_err    <= 1'b0;
      id         <= '0;
      best_valid <= 1'b0;
      best_value <= '0;
      best_id    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (count == '0) begin
          thr_min <= min_value;
          thr_res <= max_res;
        end
        if (item_sel) begin
          value_acc <= value_nxt;
          res_acc   <= res_nxt;
          sat       <= sat | sat_new;
        end
        count <= count_inc;
        if (hit_max && !item_last) len_err <= 1'b1;
      end
      if (handshake) begin
        if (better) begin
          best_valid <= 1'b1;
          best_value <= value_acc;
          best_id    <= id;
        end
        value_acc <= '0;
        res_acc   <= '0;
        sat       <= '0;
        count     <= '0;
        len_err   <= 1'b0;
        id        <= id + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_knapsack_stream_checker.sv
// Directed bench for knapsack_stream_checker with hand-computed expectations.
module tb_knapsack_stream_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] min_value = '0;
  logic [35:0] max_res = '0;
  logic        item_valid = 1'b0;
  logic        item_ready;
  logic        item_sel = 1'b0;
  logic [7:0]  item_value = '0;
  logic [23:0] item_res = '0;
  logic        item_last = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_ok;
  logic [11:0] res_value;
  logic [2:0]  res_fail_mask;
  logic        res_len_err;
  logic [15:0] res_id;
  logic        best_valid;
  logic [11:0] best_value;
  logic [15:0] best_id;

  int total = 0;
  int bad   = 0;

  knapsack_stream_checker #(.VAL_W(8), .ACC_W(12), .N_RES(3), .MAX_ITEMS(32)) dut (
    .clk(clk), .rst(rst), .min_value(min_value), .max_res(max_res),
    .item_valid(item_valid), .item_ready(item_ready), .item_sel(item_sel),
    .item_value(item_value), .item_res(item_res), .item_last(item_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok),
    .res_value(res_value), .res_fail_mask(res_fail_mask), .res_len_err(res_len_err),
    .res_id(res_id), .best_valid(best_valid), .best_value(best_value), .best_id(best_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_lim(input logic [11:0] mn, input logic [11:0] wt,
                         input logic [11:0] vol, input logic [11:0] cost);
    min_value = mn;
    max_res   = {cost, vol, wt};
  endtask

  task automatic beat(input logic sel, input logic [7:0] v, input logic [7:0] wt,
                      input logic [7:0] vol, input logic [7:0] cost, input logic last);
    int n = 0;
    item_valid = 1'b1;
    item_sel   = sel;
    item_value = v;
    item_res   = {cost, vol, wt};
    item_last  = last;
    while (!item_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("beat_timeout", 0, 1);
    @(posedge clk); #1;
    item_valid = 1'b0;
    item_last  = 1'b0;
  endtask

  task automatic collect(input logic ok, input logic [11:0] val, input logic [2:0] mask,
                         input logic lerr, input logic [15:0] idv);
    int n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("res_valid", res_valid, 1);
    check("res_ok", res_ok, ok);
    check("res_value", res_value, val);
    check("res_fail_mask", res_fail_mask, mask);
    check("res_len_err", res_len_err, lerr);
    check("res_id", res_id, idv);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic best_chk(input logic bv, input logic [11:0] val, input logic [15:0] idv);
    check("best_valid", best_valid, bv);
    check("best_value", best_value, val);
    check("best_id", best_id, idv);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_item_ready", item_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_ok", res_ok, 0);
    check("rst_res_id", res_id, 0);
    best_chk(0, 0, 0);
    rst = 1'b0;

    // Feasible candidate; thresholds altered mid-candidate must be ignored.
    set_lim(15, 16, 10, 10);
    beat(1, 10, 4, 3, 2, 0);
    set_lim(100, 0, 0, 0);
    beat(1, 2, 1, 2, 2, 0);
    beat(1, 2, 2, 1, 1, 0);
    beat(1, 1, 1, 4, 3, 1);
    check("latency_res_valid", res_valid, 1);
    item_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_res_valid", res_valid, 1);
      check("hold_item_ready", item_ready, 0);
      check("hold_res_value", res_value, 15);
      check("hold_res_ok", res_ok, 1);
    end
    item_valid = 1'b0;
    collect(1, 15, 3'b000, 0, 0);
    best_chk(1, 15, 0);

    set_lim(15, 16, 10, 10);
    beat(1, 10, 4, 3, 2, 0);
    beat(1, 20, 1, 12, 1, 1);
    collect(0, 30, 3'b010, 0, 1);
    best_chk(1, 15, 0);

    beat(1, 10, 4, 3, 2, 0);
    beat(1, 2, 1, 2, 2, 0);
    beat(1, 2, 2, 1, 1, 1);
    collect(0, 14, 3'b000, 0, 2);

    set_lim(12, 16, 10, 10);
    beat(1, 10, 4, 3, 2, 0);
    beat(1, 2, 1, 2, 2, 1);
    collect(1, 12, 3'b000, 0, 3);
    best_chk(1, 15, 0);

    // Equal value must keep the older best.
    set_lim(15, 16, 10, 10);
    beat(1, 10, 4, 3, 2, 0);
    beat(1, 2, 1, 2, 2, 0);
    beat(1, 0, 0, 0, 0, 0);
    beat(1, 3, 1, 1, 1, 1);
    collect(1, 15, 3'b000, 0, 4);
    best_chk(1, 15, 0);

    set_lim(0, 16, 10, 10);
    beat(0, 50, 1, 1, 1, 1);
    collect(1, 0, 3'b000, 0, 5);
    set_lim(1, 16, 10, 10);
    beat(0, 50, 1, 1, 1, 1);
    collect(0, 0, 3'b000, 0, 6);

    set_lim(12'hfff, 12'hfff, 12'hfff, 12'hfff);
    for (int i = 0; i < 17; i++) beat(1, 255, 0, 0, 0, i == 16);
    collect(1, 12'hfff, 3'b000, 0, 7);
    best_chk(1, 12'hfff, 7);

    set_lim(0, 12'hfff, 12'hfff, 12'hfff);
    for (int i = 0; i < 17; i++) beat(1, 0, 255, 0, 0, i == 16);
    collect(0, 0, 3'b001, 0, 8);

    set_lim(0, 12'hfff, 12'hfff, 12'hfff);
    for (int i = 0; i < 32; i++) beat(0, 9, 9, 9, 9, 0);
    check("len_res_valid", res_valid, 1);
    item_valid = 1'b1;
    item_sel   = 1'b1;
    item_value = 8'd5;
    item_res   = {8'd1, 8'd1, 8'd1};
    item_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_item_ready", item_ready, 0);
      check("stall_res_len_err", res_len_err, 1);
    end
    collect(0, 0, 3'b000, 1, 9);
    check("post_hs_item_ready", item_ready, 1);
    check("post_hs_res_valid", res_valid, 0);
    @(posedge clk); #1;
    item_valid = 1'b0;
    item_last  = 1'b0;
    collect(1, 5, 3'b000, 0, 10);
    best_chk(1, 12'hfff, 7);

    beat(1, 10, 4, 3, 2, 0);
    beat(1, 2, 1, 2, 2, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_item_ready", item_ready, 1);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_value", res_value, 0);
    check("mid_rst_res_id", res_id, 0);
    best_chk(0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_lim(0, 16, 10, 10);
    beat(1, 7, 1, 1, 1, 1);
    collect(1, 7, 3'b000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
